// File: rtl/ddr3_burst_sequencer.sv
// Command sequencer between the command/write-data FIFOs and the GoWin DDR3 controller.
// Writes pack 32-bit words into 128-bit beats; reads buffer 128-bit beats and unpack to words.
module ddr3_burst_sequencer #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned RBUF_ABITS = 6,
    parameter logic [2:0]  CMD_WRITE  = 3'b000,
    parameter logic [2:0]  CMD_READ   = 3'b001
) (
    input  logic                  ddr_clock,
    input  logic                  ddr_rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_mode,
    input  logic [5:0]            cmd_size,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic                  wd_last,
    input  logic [31:0]           wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic [31:0]           rd_data,
    output logic                  dc_valid,
    input  logic                  dc_ready,
    output logic [2:0]            dc_command,
    output logic [5:0]            dc_blength,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic                  dw_valid,
    input  logic                  dw_ready,
    output logic                  dw_last,
    output logic [15:0]           dw_stb_n,
    output logic [127:0]          dw_data,
    input  logic                  dr_valid,
    input  logic                  dr_last,
    input  logic [127:0]          dr_data,
    output logic                  wr_overflow
);

    localparam int unsigned Depth = 1 << RBUF_ABITS;
    localparam logic [RBUF_ABITS:0] DepthCount = {1'b1, {RBUF_ABITS{1'b0}}};

    typedef enum logic [2:0] {StIdle, StWcmd, StWdat, StWdrop, StRcmd, StRwait} state_e;

    state_e                  state_q;
    logic                    cmd_ready_q;
    logic                    mode_q;
    logic [5:0]              size_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    dc_valid_q;
    logic                    dw_valid_q;
    logic                    dw_last_q;
    logic [15:0]             dw_stb_n_q;
    logic [127:0]            dw_data_q;
    logic [1:0]              wlane_q;
    logic [5:0]              wbeat_q;
    logic                    frame_end_q;
    logic                    wr_overflow_q;
    logic [5:0]              rbeat_q;
    logic [RBUF_ABITS:0]     wptr_q;
    logic [RBUF_ABITS:0]     rptr_q;
    logic [1:0]              rlane_q;
    logic                    rd_valid_q;
    logic                    rd_last_q;
    logic [31:0]             rd_data_q;

    // Entry = {last-beat tag, beat data}
    logic [128:0]            rbuf_mem [Depth];

    logic [RBUF_ABITS:0]     rbuf_count;
    logic [RBUF_ABITS:0]     rbuf_free;
    logic [RBUF_ABITS:0]     cmd_need;
    logic [RBUF_ABITS:0]     size_need;
    logic [128:0]            rbuf_head;
    logic                    unused_dr_last;

    // The controller's own last flag is redundant: beats are counted locally.
    assign unused_dr_last = dr_last;

    assign rbuf_count = wptr_q - rptr_q;
    assign rbuf_free  = DepthCount - rbuf_count;
    assign cmd_need   = (RBUF_ABITS+1)'(cmd_size) + (RBUF_ABITS+1)'(1);
    assign size_need  = (RBUF_ABITS+1)'(size_q) + (RBUF_ABITS+1)'(1);
    assign rbuf_head  = rbuf_mem[rptr_q[RBUF_ABITS-1:0]];

    assign cmd_ready   = cmd_ready_q;
    assign wd_ready    = ((state_q == StWdat) && !dw_valid_q && !frame_end_q) ||
                         (state_q == StWdrop);
    assign dc_valid    = dc_valid_q;
    assign dc_command  = mode_q ? CMD_WRITE : CMD_READ;
    assign dc_blength  = size_q;
    assign dc_addr     = addr_q;
    assign dw_valid    = dw_valid_q;
    assign dw_last     = dw_last_q;
    assign dw_stb_n    = dw_stb_n_q;
    assign dw_data     = dw_data_q;
    assign wr_overflow = wr_overflow_q;
    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign rd_data     = rd_data_q;

    // Main FSM: command issue, write-beat packing and read-beat counting
    always_ff @(posedge ddr_clock or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            mode_q        <= 1'b0;
            size_q        <= '0;
            addr_q        <= '0;
            dc_valid_q    <= 1'b0;
            dw_valid_q    <= 1'b0;
            dw_last_q     <= 1'b0;
            dw_stb_n_q    <= '1;
            dw_data_q     <= '0;
            wlane_q       <= '0;
            wbeat_q       <= '0;
            frame_end_q   <= 1'b0;
            wr_overflow_q <= 1'b0;
            rbeat_q       <= '0;
            wptr_q        <= '0;
        end else begin
            wr_overflow_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        mode_q      <= cmd_mode;
                        size_q      <= cmd_size;
                        addr_q      <= cmd_addr;
                        if (cmd_mode) begin
                            state_q    <= StWcmd;
                            dc_valid_q <= 1'b1;
                        end else begin
                            // Free space only grows while idle, so this check cannot go stale
                            state_q    <= StRcmd;
                            dc_valid_q <= (rbuf_free >= cmd_need);
                        end
                    end
                end
                StWcmd: begin
                    if (dc_ready) begin
                        dc_valid_q  <= 1'b0;
                        state_q     <= StWdat;
                        wbeat_q     <= '0;
                        wlane_q     <= '0;
                        frame_end_q <= 1'b0;
                        dw_data_q   <= '0;
                        dw_stb_n_q  <= '1;
                    end
                end
                StWdat: begin
                    if (dw_valid_q) begin
                        if (dw_ready) begin
                            dw_valid_q <= 1'b0;
                            dw_last_q  <= 1'b0;
                            dw_data_q  <= '0;
                            dw_stb_n_q <= '1;
                            wbeat_q    <= wbeat_q + 6'd1;
                            if (wbeat_q == size_q) begin
                                state_q <= frame_end_q ? StIdle : StWdrop;
                            end
                        end
                    end else if (frame_end_q) begin
                        // Short frame: remaining beats go out fully masked
                        dw_valid_q <= 1'b1;
                        dw_last_q  <= (wbeat_q == size_q);
                    end else if (wd_valid) begin
                        dw_data_q[{wlane_q, 5'b0} +: 32] <= wd_data;
                        dw_stb_n_q[{wlane_q, 2'b0} +: 4] <= 4'h0;
                        wlane_q <= wlane_q + 2'd1;
                        if ((wlane_q == 2'd3) || wd_last) begin
                            dw_valid_q  <= 1'b1;
                            dw_last_q   <= (wbeat_q == size_q);
                            wlane_q     <= '0;
                            frame_end_q <= wd_last;
                        end
                    end
                end
                StWdrop: begin
                    if (wd_valid && wd_last) begin
                        wr_overflow_q <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                StRcmd: begin
                    if (dc_valid_q) begin
                        if (dc_ready) begin
                            dc_valid_q <= 1'b0;
                            rbeat_q    <= '0;
                            state_q    <= StRwait;
                        end
                    end else if (rbuf_free >= size_need) begin
                        dc_valid_q <= 1'b1;
                    end
                end
                StRwait: begin
                    if (dr_valid) begin
                        wptr_q  <= wptr_q + (RBUF_ABITS+1)'(1);
                        rbeat_q <= rbeat_q + 6'd1;
                        if (rbeat_q == size_q) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read buffer storage; only the pointers need reset
    always_ff @(posedge ddr_clock) begin
        if ((state_q == StRwait) && dr_valid) begin
            rbuf_mem[wptr_q[RBUF_ABITS-1:0]] <= {(rbeat_q == size_q), dr_data};
        end
    end

    // Unpack head beat into four words; a beat is popped when its lane 3 is loaded
    always_ff @(posedge ddr_clock or negedge ddr_rst_n) begin
        if (!ddr_rst_n) begin
            rptr_q     <= '0;
            rlane_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else if ((!rd_valid_q || rd_ready) && (rbuf_count != '0)) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= rbuf_head[{rlane_q, 5'b0} +: 32];
            rd_last_q  <= rbuf_head[128] && (rlane_q == 2'd3);
            rlane_q    <= rlane_q + 2'd1;
            if (rlane_q == 2'd3) begin
                rptr_q <= rptr_q + (RBUF_ABITS+1)'(1);
            end
        end else if (rd_ready) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end
    end

endmodule
